// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit.
// Package rv32i_types:
//   load_funct3_t  - RV32I load funct3 encodings
//   store_funct3_t - RV32I store funct3 encodings
//   lsu_state_t    - LSU sequencer states (IDLE/BUSY/DONE)
//   acc_size()     - access width decoded from funct3
//   is_misaligned()- natural-alignment check for an access
package rv32i_types;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Unknown encodings fall back to a full word access.
    function automatic acc_size_t acc_size(input logic is_load, input logic [2:0] f3);
        acc_size_t sz;
        sz = SZ_WORD;
        if (is_load) begin
            case (f3)
                LD_LB, LD_LBU: sz = SZ_BYTE;
                LD_LH, LD_LHU: sz = SZ_HALF;
                default:       sz = SZ_WORD;
            endcase
        end else begin
            case (f3)
                ST_SB:   sz = SZ_BYTE;
                ST_SH:   sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic is_load, input logic [2:0] f3,
                                           input logic [1:0] off);
        acc_size_t sz;
        sz = acc_size(is_load, f3);
        return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage LSU.
// modport slave  : the LSU (consumes EX/MEM fields and dmem response,
//                  drives dmem request, load_data, stall, misaligned)
// modport master : the environment (pipeline + data memory)
interface mem_stage_lsu_if;
    logic        valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        advance;
    logic        flush;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misaligned;

    modport slave (
        input  valid, is_load, is_store, funct3, addr, store_data, advance, flush,
        input  dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_wmask,
        output load_data, stall, misaligned
    );

    modport master (
        output valid, is_load, is_store, funct3, addr, store_data, advance, flush,
        output dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_wmask,
        input  load_data, stall, misaligned
    );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational byte-lane steering for the LSU.
// Ports:
//   rdata      in  32  raw memory word
//   offset     in  2   byte offset within the word
//   funct3     in  3   access size/sign
//   store_data in  32  unshifted store operand
//   load_data  out 32  extended load result
//   wmask      out 4   store byte enables
//   wdata      out 32  store data replicated across lanes
// Halfwords are selected by offset[1] only; offset[0] is ignored for them.
module lsu_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [3:0]  wmask,
    output logic [31:0] wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data = rdata;
        case (funct3)
            LD_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            LD_LBU:  load_data = {24'h0, byte_sel};
            LD_LHU:  load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        wmask = 4'b1111;
        wdata = store_data;
        case (acc_size(1'b0, funct3))
            SZ_BYTE: begin
                wmask = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                wmask = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store sequencer for the RV32I pipeline.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   lsu  mem_stage_lsu_if.slave: EX/MEM fields, advance/flush, dmem
//        request/response, load_data, stall, misaligned
// Build option: LSU_MISALIGN_TRAP_EN - misaligned half/word accesses are
// not issued; the unit goes straight to DONE with misaligned=1, load_data=0.
//
// state | meaning
// IDLE  | no access pending; accepts a new load/store
// BUSY  | request held on dmem until dmem_resp
// DONE  | result ready, waits for advance (or flush)
module mem_stage_lsu
    import rv32i_types::*;
(
    input  logic           clk,
    input  logic           rst,
    mem_stage_lsu_if.slave lsu
);

    lsu_state_t  state_q, state_d;
    logic [29:0] word_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic [31:0] sdata_q;
    logic        flushed_q;
    logic [31:0] load_data_q;
    logic        start;
    logic        trap;
    logic        req;
    logic [31:0] fmt_data;
    logic [31:0] al_wdata;
    logic [3:0]  al_wmask;

    lsu_align u_align (
        .rdata      (lsu.dmem_rdata),
        .offset     (off_q),
        .funct3     (f3_q),
        .store_data (sdata_q),
        .load_data  (fmt_data),
        .wmask      (al_wmask),
        .wdata      (al_wdata)
    );

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap = is_misaligned(lsu.is_load, lsu.funct3, lsu.addr[1:0]);
    assign lsu.misaligned = (state_q == DONE) && mis_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q <= 1'b0;
        end else if (start) begin
            mis_q <= trap;
        end
    end
`else
    assign trap = 1'b0;
    assign lsu.misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu.valid && (lsu.is_load || lsu.is_store) && !lsu.flush) begin
                    start   = 1'b1;
                    state_d = trap ? DONE : BUSY;
                end
            end
            BUSY: begin
                // A flushed access still has to drain; its data is dropped.
                if (lsu.dmem_resp) begin
                    state_d = (flushed_q || lsu.flush) ? IDLE : DONE;
                end
            end
            DONE: begin
                if (lsu.advance || lsu.flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req            = (state_q == BUSY);
    assign lsu.dmem_read  = req && load_q;
    assign lsu.dmem_write = req && !load_q;
    assign lsu.dmem_addr  = {word_q, 2'b00};
    assign lsu.dmem_wmask = lsu.dmem_write ? al_wmask : 4'b0000;
    assign lsu.dmem_wdata = lsu.dmem_write ? al_wdata : 32'h0;
    assign lsu.load_data  = load_data_q;
    // start depends on live inputs, so gate with reset to keep stall low in reset.
    assign lsu.stall      = rst && (start || req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            load_q      <= 1'b0;
            sdata_q     <= '0;
            flushed_q   <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                word_q    <= lsu.addr[31:2];
                off_q     <= lsu.addr[1:0];
                f3_q      <= lsu.funct3;
                load_q    <= lsu.is_load;
                sdata_q   <= lsu.store_data;
                flushed_q <= 1'b0;
                if (trap) begin
                    load_data_q <= '0;
                end
            end
            if (req && lsu.flush) begin
                flushed_q <= 1'b1;
            end
            if (req && lsu.dmem_resp && load_q && !flushed_q && !lsu.flush) begin
                load_data_q <= fmt_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [31:0] exp_load_q[$];
    logic [3:0]  exp_mask_q[$];
    logic [31:0] exp_wdata_q[$];
    logic [31:0] model_ld;

    mem_stage_lsu_if bus ();

    mem_stage_lsu dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * off);
        h = off[1] ? (w >> 16) : w;
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return w;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.valid      = 1'b0;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b0;
        bus.funct3     = 3'b000;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        bus.advance    = 1'b0;
        bus.flush      = 1'b0;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd);
        bus.valid      = 1'b1;
        bus.is_load    = ld;
        bus.is_store   = !ld;
        bus.funct3     = f3;
        bus.addr       = a;
        bus.store_data = sd;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        cyc();
        cyc();
        bus.valid   = 1'b1;
        bus.is_load = 1'b1;
        #1;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL rst_stall got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL rst_read got %b want 0", bus.dmem_read); else n_pass++;
        n_total++; if (bus.dmem_write !== 1'b0) $display("FAIL rst_write got %b want 0", bus.dmem_write); else n_pass++;
        n_total++; if (bus.dmem_wmask !== 4'h0) $display("FAIL rst_wmask got %h want 0", bus.dmem_wmask); else n_pass++;
        n_total++; if (bus.dmem_wdata !== 32'h0) $display("FAIL rst_wdata got %h want 0", bus.dmem_wdata); else n_pass++;
        n_total++; if (bus.dmem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", bus.dmem_addr); else n_pass++;
        n_total++; if (bus.load_data !== 32'h0) $display("FAIL rst_load_data got %h want 0", bus.load_data); else n_pass++;
        n_total++; if (bus.misaligned !== 1'b0) $display("FAIL rst_misaligned got %b want 0", bus.misaligned); else n_pass++;
        idle_inputs();
        cyc();
        rst = 1'b1;
        model_ld = 32'h0;
        cyc();
    endtask

    task automatic test_load_byte();
        logic [31:0] e;
        cyc();
        issue(1'b1, 3'b000, 32'h0000_0103, 32'h0);
        exp_load_q.push_back(model_load(3'b000, 2'd3, 32'h80FF_0000));
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) cyc();
            if (c == 3) begin
                bus.dmem_resp  = 1'b1;
                bus.dmem_rdata = 32'h80FF_0000;
            end
            #1;
            n_total++; if (bus.stall !== 1'b1) $display("FAIL lb_stall c%0d got %b want 1", c, bus.stall); else n_pass++;
            n_total++; if (bus.dmem_read !== (c > 0)) $display("FAIL lb_read c%0d got %b want %b", c, bus.dmem_read, c > 0); else n_pass++;
            if (c == 1) begin
                n_total++; if (bus.dmem_addr !== 32'h0000_0100) $display("FAIL lb_addr got %h want 00000100", bus.dmem_addr); else n_pass++;
            end
        end
        cyc();
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        bus.advance    = 1'b1;
        #1;
        e = exp_load_q.pop_front();
        model_ld = e;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL lb_done_stall got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL lb_done_read got %b want 0", bus.dmem_read); else n_pass++;
        n_total++; if (bus.load_data !== e) $display("FAIL lb_data got %h want %h", bus.load_data, e); else n_pass++;
        cyc();
        idle_inputs();
        #1;
        n_total++; if (bus.load_data !== model_ld) $display("FAIL lb_hold got %h want %h", bus.load_data, model_ld); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL lb_idle_stall got %b want 0", bus.stall); else n_pass++;
    endtask

    task automatic test_store_lanes();
        logic [2:0]  f3 [5] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b001};
        logic [31:0] ad [5] = '{32'h102, 32'h101, 32'h103, 32'h200, 32'h100};
        logic [31:0] sd [5] = '{32'h1234_ABCD, 32'h0000_00EF, 32'h1122_3344, 32'hDEAD_BEEF, 32'h0000_5A5A};
        logic [3:0]  mk [5] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111, 4'b0011};
        logic [31:0] wd [5] = '{32'hABCD_ABCD, 32'hEFEF_EFEF, 32'h4444_4444, 32'hDEAD_BEEF, 32'h5A5A_5A5A};
        logic [3:0]  em;
        logic [31:0] ew;
        for (int i = 0; i < 5; i++) begin
            cyc();
            issue(1'b0, f3[i], ad[i], sd[i]);
            exp_mask_q.push_back(mk[i]);
            exp_wdata_q.push_back(wd[i]);
            #1;
            n_total++; if (bus.stall !== 1'b1) $display("FAIL st%0d_issue_stall got %b want 1", i, bus.stall); else n_pass++;
            cyc();
            bus.dmem_resp = 1'b1;
            #1;
            em = exp_mask_q.pop_front();
            ew = exp_wdata_q.pop_front();
            n_total++; if (bus.dmem_write !== 1'b1) $display("FAIL st%0d_write got %b want 1", i, bus.dmem_write); else n_pass++;
            n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL st%0d_read got %b want 0", i, bus.dmem_read); else n_pass++;
            n_total++; if (bus.dmem_addr !== {ad[i][31:2], 2'b00}) $display("FAIL st%0d_addr got %h want %h", i, bus.dmem_addr, {ad[i][31:2], 2'b00}); else n_pass++;
            n_total++; if (bus.dmem_wmask !== em) $display("FAIL st%0d_wmask got %b want %b", i, bus.dmem_wmask, em); else n_pass++;
            n_total++; if (bus.dmem_wdata !== ew) $display("FAIL st%0d_wdata got %h want %h", i, bus.dmem_wdata, ew); else n_pass++;
            cyc();
            bus.dmem_resp = 1'b0;
            bus.advance   = 1'b1;
            #1;
            n_total++; if (bus.stall !== 1'b0) $display("FAIL st%0d_done_stall got %b want 0", i, bus.stall); else n_pass++;
            n_total++; if ({bus.dmem_write, bus.dmem_wmask, bus.dmem_wdata} !== 37'h0) $display("FAIL st%0d_idle_bus got %b/%b/%h want 0", i, bus.dmem_write, bus.dmem_wmask, bus.dmem_wdata); else n_pass++;
            n_total++; if (bus.load_data !== model_ld) $display("FAIL st%0d_load_data got %h want %h", i, bus.load_data, model_ld); else n_pass++;
            cyc();
            idle_inputs();
        end
    endtask

    task automatic test_load_formats();
        logic [2:0]  f3 [7] = '{3'b001, 3'b101, 3'b001, 3'b100, 3'b000, 3'b010, 3'b011};
        logic [31:0] ad [7] = '{32'h102, 32'h102, 32'h100, 32'h101, 32'h102, 32'h104, 32'h108};
        logic [31:0] rd [7];
        logic [31:0] e;
        rd[0] = 32'h8001_7FFF;
        rd[1] = 32'h8001_7FFF;
        rd[2] = 32'h1234_F00D;
        rd[3] = 32'h0000_9A00;
        rd[4] = 32'h0042_0000;
        rd[5] = $urandom;
        rd[6] = $urandom;
        for (int i = 0; i < 7; i++) begin
            cyc();
            issue(1'b1, f3[i], ad[i], 32'h0);
            exp_load_q.push_back(model_load(f3[i], ad[i][1:0], rd[i]));
            cyc();
            bus.dmem_resp  = 1'b1;
            bus.dmem_rdata = rd[i];
            #1;
            n_total++; if (bus.dmem_read !== 1'b1) $display("FAIL ld%0d_read got %b want 1", i, bus.dmem_read); else n_pass++;
            cyc();
            bus.dmem_resp  = 1'b0;
            bus.dmem_rdata = 32'h0;
            bus.advance    = 1'b1;
            #1;
            e = exp_load_q.pop_front();
            model_ld = e;
            n_total++; if (bus.load_data !== e) $display("FAIL ld%0d_data f3=%0d got %h want %h", i, f3[i], bus.load_data, e); else n_pass++;
            n_total++; if (bus.stall !== 1'b0) $display("FAIL ld%0d_stall got %b want 0", i, bus.stall); else n_pass++;
            cyc();
            idle_inputs();
        end
    endtask

    task automatic test_back_to_back_hold();
        int          rises = 0;
        int          high  = 0;
        logic        prev  = 1'b0;
        logic [31:0] e;
        cyc();
        issue(1'b1, 3'b010, 32'h0000_0300, 32'h0);
        exp_load_q.push_back(32'hCAFE_F00D);
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) cyc();
            bus.dmem_resp  = (c == 2);
            bus.dmem_rdata = (c == 2) ? 32'hCAFE_F00D : 32'h0;
            bus.advance    = (c == 6);
            #1;
            if (bus.dmem_read && !prev) rises++;
            if (bus.dmem_read) high++;
            prev = bus.dmem_read;
            if (c == 3) begin
                e = exp_load_q.pop_front();
                model_ld = e;
            end
            if (c >= 3) begin
                n_total++; if (bus.load_data !== model_ld) $display("FAIL hold_data c%0d got %h want %h", c, bus.load_data, model_ld); else n_pass++;
                n_total++; if (bus.stall !== 1'b0) $display("FAIL hold_stall c%0d got %b want 0", c, bus.stall); else n_pass++;
            end
        end
        n_total++; if (rises !== 1) $display("FAIL hold_bursts got %0d want 1", rises); else n_pass++;
        n_total++; if (high !== 2) $display("FAIL hold_read_cycles got %0d want 2", high); else n_pass++;
        cyc();
        idle_inputs();
        #1;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL hold_after_read got %b want 0", bus.dmem_read); else n_pass++;
    endtask

    task automatic test_flush_busy();
        cyc();
        issue(1'b1, 3'b100, 32'h0000_0102, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            bus.flush = (c == 1);
            if (c == 2) bus.valid = 1'b0;
            bus.dmem_resp  = (c == 3);
            bus.dmem_rdata = (c == 3) ? 32'h00AB_0000 : 32'h0;
            #1;
            n_total++; if (bus.dmem_read !== 1'b1) $display("FAIL flush_read c%0d got %b want 1", c, bus.dmem_read); else n_pass++;
        end
        cyc();
        idle_inputs();
        #1;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL flush_stall got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL flush_read_end got %b want 0", bus.dmem_read); else n_pass++;
        n_total++; if (bus.load_data !== model_ld) $display("FAIL flush_data got %h want %h", bus.load_data, model_ld); else n_pass++;
        cyc();
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        #1;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL idle_resp_read got %b want 0", bus.dmem_read); else n_pass++;
        cyc();
        idle_inputs();
        #1;
        n_total++; if (bus.load_data !== model_ld) $display("FAIL idle_resp_data got %h want %h", bus.load_data, model_ld); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL idle_resp_stall got %b want 0", bus.stall); else n_pass++;
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        cyc();
        issue(1'b1, 3'b010, 32'h0000_0102, 32'h0);
        #1;
        n_total++; if (bus.stall !== 1'b1) $display("FAIL mis_issue_stall got %b want 1", bus.stall); else n_pass++;
        cyc();
        bus.advance = 1'b1;
        #1;
        model_ld = 32'h0;
        n_total++; if (bus.misaligned !== 1'b1) $display("FAIL mis_flag got %b want 1", bus.misaligned); else n_pass++;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL mis_read got %b want 0", bus.dmem_read); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL mis_stall got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.load_data !== 32'h0) $display("FAIL mis_data got %h want 0", bus.load_data); else n_pass++;
        cyc();
        idle_inputs();
        #1;
        n_total++; if (bus.misaligned !== 1'b0) $display("FAIL mis_flag_clear got %b want 0", bus.misaligned); else n_pass++;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL mis_read_after got %b want 0", bus.dmem_read); else n_pass++;
`else
        logic [31:0] e;
        cyc();
        issue(1'b1, 3'b001, 32'h0000_0101, 32'h0);
        exp_load_q.push_back(32'hFFFF_8765);
        cyc();
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h1234_8765;
        #1;
        n_total++; if (bus.dmem_read !== 1'b1) $display("FAIL odd_lh_read got %b want 1", bus.dmem_read); else n_pass++;
        n_total++; if (bus.misaligned !== 1'b0) $display("FAIL odd_lh_flag got %b want 0", bus.misaligned); else n_pass++;
        cyc();
        bus.dmem_resp = 1'b0;
        bus.advance   = 1'b1;
        #1;
        e = exp_load_q.pop_front();
        model_ld = e;
        n_total++; if (bus.load_data !== e) $display("FAIL odd_lh_data got %h want %h", bus.load_data, e); else n_pass++;
        n_total++; if (bus.misaligned !== 1'b0) $display("FAIL odd_lh_flag_done got %b want 0", bus.misaligned); else n_pass++;
        cyc();
        idle_inputs();
`endif
    endtask

    task automatic test_reset_busy();
        cyc();
        issue(1'b1, 3'b010, 32'h0000_0400, 32'h0);
        cyc();
        #1;
        n_total++; if (bus.dmem_read !== 1'b1) $display("FAIL rb_read_pre got %b want 1", bus.dmem_read); else n_pass++;
        cyc();
        rst = 1'b0;
        #1;
        model_ld = 32'h0;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL rb_read got %b want 0", bus.dmem_read); else n_pass++;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL rb_stall got %b want 0", bus.stall); else n_pass++;
        n_total++; if (bus.load_data !== 32'h0) $display("FAIL rb_data got %h want 0", bus.load_data); else n_pass++;
        cyc();
        idle_inputs();
        rst = 1'b1;
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        #1;
        n_total++; if (bus.stall !== 1'b0) $display("FAIL rb_resp_stall got %b want 0", bus.stall); else n_pass++;
        cyc();
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
        #1;
        n_total++; if (bus.load_data !== model_ld) $display("FAIL rb_resp_data got %h want %h", bus.load_data, model_ld); else n_pass++;
        n_total++; if (bus.dmem_read !== 1'b0) $display("FAIL rb_resp_read got %b want 0", bus.dmem_read); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        model_ld = 32'h0;
        idle_inputs();
        test_reset();
        test_load_byte();
        test_store_lanes();
        test_load_formats();
        test_back_to_back_hold();
        test_flush_busy();
        test_misalign();
        test_reset_busy();
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
